// File: rtl/pixel_row_packer.sv
// Packs binary pixel beats into one row of inverted Gray codes and hands the row
// out over a valid/ready bus, tracking the row index within a frame.
module pixel_row_packer #(
  parameter int unsigned BIT_DEPTH             = 8,
  parameter int unsigned WIDTH                 = 2,
  parameter int unsigned INPUT_BUS_PIXEL_WIDTH = 2,
  parameter int unsigned HEIGHT                = 2,
  localparam int unsigned IDX_W                = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                                       CLK,
  input  logic                                       RESET_N,
  input  logic                                       IN_VALID,
  output logic                                       IN_READY,
  input  logic [INPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] IN_DATA,
  output logic                                       ROW_VALID,
  input  logic                                       ROW_READY,
  output logic [WIDTH*BIT_DEPTH-1:0]                 ROW_DATA,
  output logic [IDX_W-1:0]                           ROW_INDEX,
  output logic                                       FRAME_DONE
);

  localparam int unsigned BEATS  = WIDTH / INPUT_BUS_PIXEL_WIDTH;
  localparam int unsigned BEAT_W = INPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam int unsigned ROW_W  = WIDTH * BIT_DEPTH;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ROW_W-1:0]   row_buf_q, row_buf_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;
  logic               frame_done_q, frame_done_d;
  logic               in_ready_q;
  logic               row_valid_q;
  logic [BEAT_W-1:0]  enc_beat;

  // Each pixel becomes ~(b ^ (b >> 1)), so an unwritten all-ones slice decodes to 0.
  function automatic logic [BEAT_W-1:0] encode_beat(input logic [BEAT_W-1:0] beat);
    logic [BEAT_W-1:0]    enc;
    logic [BIT_DEPTH-1:0] b;
    enc = '0;
    for (int unsigned p = 0; p < INPUT_BUS_PIXEL_WIDTH; p++) begin
      b = beat[p*BIT_DEPTH +: BIT_DEPTH];
      enc[p*BIT_DEPTH +: BIT_DEPTH] = ~(b ^ (b >> 1));
    end
    return enc;
  endfunction

  assign enc_beat = encode_beat(IN_DATA);

  // Next-state, buffer fill and row hand-off.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    row_buf_d    = row_buf_q;
    row_idx_d    = row_idx_q;
    frame_done_d = 1'b0;
    case (state_q)
      FILL: begin
        if (IN_VALID) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_cnt_q == CNT_W'(k)) begin
              row_buf_d[k*BEAT_W +: BEAT_W] = enc_beat;
            end
          end
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (ROW_READY) begin
          row_buf_d = '1;
          state_d   = FILL;
          if (row_idx_q == IDX_W'(HEIGHT - 1)) begin
            row_idx_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            row_idx_d = row_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= FILL;
      beat_cnt_q   <= '0;
      row_buf_q    <= '1;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
      row_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      row_buf_q    <= row_buf_d;
      row_idx_q    <= row_idx_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= (state_d == FILL);
      row_valid_q  <= (state_d == HOLD);
    end
  end

  assign IN_READY   = in_ready_q;
  assign ROW_VALID  = row_valid_q;
  assign ROW_DATA   = row_buf_q;
  assign ROW_INDEX  = row_idx_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_pixel_row_packer.sv
// Scoreboard bench for pixel_row_packer: 4-pixel rows of 8-bit pixels, 2 pixels per beat,
// 2 rows per frame; rows are also decoded the way the bus receiver recovers pixels.
module tb_pixel_row_packer;

  localparam int unsigned BD   = 8;
  localparam int unsigned W    = 4;
  localparam int unsigned IBPW = 2;
  localparam int unsigned H    = 2;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic        ROW_VALID;
  logic        ROW_READY;
  logic [31:0] ROW_DATA;
  logic [0:0]  ROW_INDEX;
  logic        FRAME_DONE;

  pixel_row_packer #(
    .BIT_DEPTH(BD), .WIDTH(W), .INPUT_BUS_PIXEL_WIDTH(IBPW), .HEIGHT(H)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY), .ROW_DATA(ROW_DATA),
    .ROW_INDEX(ROW_INDEX), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pix;
    bit          chk_data;
    logic [0:0]  idx;
    bit          fd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   model_idx = 0;
  bit   fd_pend = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Receiver view: undo the inversion, then Gray-decode MSB down.
  function automatic logic [31:0] rx_decode(input logic [31:0] row);
    logic [31:0] out;
    logic [7:0]  g;
    logic [7:0]  b;
    out = '0;
    for (int p = 0; p < int'(W); p++) begin
      g = ~row[p*BD +: BD];
      b = '0;
      b[BD-1] = g[BD-1];
      for (int i = int'(BD) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      out[p*BD +: BD] = b;
    end
    return out;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_row(input logic [31:0] pix, input logic [31:0] data, input bit chk);
    exp_t e;
    e.pix      = pix;
    e.data     = data;
    e.chk_data = chk;
    e.idx      = 1'(model_idx);
    e.fd       = (model_idx == int'(H) - 1);
    model_idx  = e.fd ? 0 : model_idx + 1;
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [15:0] d, input bit keep);
    bit ready;
    bit done;
    int n;
    n = 0;
    done = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    while (!done) begin
      ready = IN_READY;
      tick();
      if (ready) done = 1'b1;
      else begin
        n++;
        if (n > 50) begin
          total++;
          bad++;
          $display("FAIL beat_timeout: beat %h not accepted in 50 cycles", d);
          done = 1'b1;
        end
      end
    end
    if (!keep) IN_VALID = 1'b0;
  endtask

  task automatic send_row(input logic [31:0] pix, input logic [31:0] data, input bit chk,
                          input bit keep);
    push_row(pix, data, chk);
    send_beat(pix[15:0], 1'b1);
    send_beat(pix[31:16], keep);
  endtask

  // Monitor: pops at every row handshake and checks the following FRAME_DONE cycle.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      fd_pend = 1'b0;
    end else begin
      if (fd_pend || FRAME_DONE) check("frame_done", 32'(FRAME_DONE), 32'(fd_pend));
      fd_pend = 1'b0;
      if (ROW_VALID && ROW_READY) begin
        if (sb.size() == 0) begin
          check("unexpected_row", ROW_DATA, 32'hx);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.chk_data) check("row_data", ROW_DATA, mon_e.data);
          check("rx_pixels", rx_decode(ROW_DATA), mon_e.pix);
          check("row_index", 32'(ROW_INDEX), 32'(mon_e.idx));
          fd_pend = mon_e.fd;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET_N   = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    ROW_READY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_row_valid", 32'(ROW_VALID), 32'd0);
    check("rst_row_data", ROW_DATA, 32'hFFFFFFFF);
    check("rst_row_index", 32'(ROW_INDEX), 32'd0);
    check("rst_frame_done", 32'(FRAME_DONE), 32'd0);

    // Encode and hold stability
    send_row(32'hFF800201, 32'h7F3FFCFE, 1'b1, 1'b0);
    check("enc_latency_valid", 32'(ROW_VALID), 32'd1);
    check("enc_row_data", ROW_DATA, 32'h7F3FFCFE);
    repeat (5) begin
      tick();
      check("hold_stable_data", ROW_DATA, 32'h7F3FFCFE);
      check("hold_in_ready", 32'(IN_READY), 32'd0);
      check("hold_row_valid", 32'(ROW_VALID), 32'd1);
    end
    ROW_READY = 1'b1;
    tick();
    ROW_READY = 1'b0;
    check("acc_row_valid", 32'(ROW_VALID), 32'd0);
    check("acc_in_ready", 32'(IN_READY), 32'd1);
    check("acc_buf_ones", ROW_DATA, 32'hFFFFFFFF);
    check("acc_frame_done0", 32'(FRAME_DONE), 32'd0);

    // Backpressure: IN_VALID held high through HOLD
    send_row(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    repeat (3) begin
      tick();
      check("bp_in_ready", 32'(IN_READY), 32'd0);
      check("bp_row_valid", 32'(ROW_VALID), 32'd1);
    end
    ROW_READY = 1'b1;
    tick();
    ROW_READY = 1'b0;
    check("bp_m_in_ready", 32'(IN_READY), 32'd1);
    check("bp_m_row_valid", 32'(ROW_VALID), 32'd0);
    check("bp_m_frame_done", 32'(FRAME_DONE), 32'd1);
    push_row(32'h00000000, 32'hFFFFFFFF, 1'b1);
    tick();
    check("bp_m1_row_valid", 32'(ROW_VALID), 32'd0);
    check("bp_m1_frame_done", 32'(FRAME_DONE), 32'd0);
    tick();
    IN_VALID = 1'b0;
    check("bp_m2_row_valid", 32'(ROW_VALID), 32'd1);
    check("bp_m2_row_data", ROW_DATA, 32'hFFFFFFFF);
    ROW_READY = 1'b1;
    tick();
    ROW_READY = 1'b0;

    // Gaps in IN_VALID: 1,0,0,1
    push_row(32'h55AA0300, 32'h8000FDFF, 1'b1);
    IN_VALID = 1'b1;
    IN_DATA  = 16'h0300;
    tick();
    check("gap_valid_c1", 32'(ROW_VALID), 32'd0);
    IN_VALID = 1'b0;
    IN_DATA  = 16'hDEAD;
    tick();
    check("gap_valid_c2", 32'(ROW_VALID), 32'd0);
    tick();
    check("gap_valid_c3", 32'(ROW_VALID), 32'd0);
    IN_VALID = 1'b1;
    IN_DATA  = 16'h55AA;
    tick();
    IN_VALID = 1'b0;
    check("gap_valid_c4", 32'(ROW_VALID), 32'd1);
    check("gap_row_data", ROW_DATA, 32'h8000FDFF);
    ROW_READY = 1'b1;
    tick();
    ROW_READY = 1'b0;
    check("gap_frame_done", 32'(FRAME_DONE), 32'd1);

    // Frame wrap with ROW_READY tied high
    ROW_READY = 1'b1;
    send_row(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    check("wrap_idx_r0", 32'(ROW_INDEX), 32'd0);
    send_row(32'hFF800201, 32'h7F3FFCFE, 1'b1, 1'b1);
    check("wrap_idx_r1", 32'(ROW_INDEX), 32'd1);
    send_row(32'h55AA0300, 32'h8000FDFF, 1'b1, 1'b0);
    check("wrap_idx_r2", 32'(ROW_INDEX), 32'd0);
    tick();
    ROW_READY = 1'b0;
    check("wrap_idx_after", 32'(ROW_INDEX), 32'd1);

    // Asynchronous reset mid-row
    send_beat(16'h0201, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mr_in_ready", 32'(IN_READY), 32'd1);
    check("mr_row_valid", 32'(ROW_VALID), 32'd0);
    check("mr_row_data", ROW_DATA, 32'hFFFFFFFF);
    check("mr_row_index", 32'(ROW_INDEX), 32'd0);
    check("mr_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    model_idx = 0;
    @(negedge CLK);
    #1;
    RESET_N = 1'b1;
    tick();
    send_row(32'h55AA0300, 32'h8000FDFF, 1'b1, 1'b0);
    check("mr_clean_valid", 32'(ROW_VALID), 32'd1);
    check("mr_clean_data", ROW_DATA, 32'h8000FDFF);
    check("mr_clean_index", 32'(ROW_INDEX), 32'd0);
    ROW_READY = 1'b1;
    tick();
    ROW_READY = 1'b0;

    // Loopback of random rows through the receiver decode
    ROW_READY = 1'b1;
    repeat (100) send_row($urandom, 32'h0, 1'b0, 1'b1);
    IN_VALID = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    ROW_READY = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
